// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
//  Package : iir_pkg
//  Purpose : Shared IEEE-754 single-precision field layout, constants and
//            operand classification for the IIR float-to-fixed output stage.
//  Contents: float_t struct, FLT_* constants, fclass_t enum, classify().
//  Revision: 1.0  initial release
// ============================================================================
package iir_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } float_t;

    localparam int FLT_BIAS    = 127;
    localparam int FLT_MAN_W   = 23;
    localparam int FLT_EXP_MAX = 255;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fclass_t;

    // Denormals are deliberately folded into ZERO: their magnitude is far
    // below one LSB for every supported FRAC_BITS.
    function automatic fclass_t classify(input float_t f);
        fclass_t c;
        if (f.exp == 8'd0)
            c = ZERO;
        else if (f.exp == 8'(FLT_EXP_MAX))
            c = (f.man != '0) ? NAN : INF;
        else
            c = NORM;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iir_f2q_sat.sv
`default_nettype none
// ============================================================================
//  Module  : iir_f2q_sat
//  Purpose : Combinational final stage of the float-to-fixed converter:
//            optional round-half-away, sign application, saturation, flags.
//  Ports   : sign, cls, mag, pre_ovf, [guard]  -> aligned operand
//            value, flag_ovf, flag_nan         -> fixed-point result
//  Config  : IIR_F2Q_ROUND_EN selects round-to-nearest (ties away) instead
//            of truncation toward zero; the guard port exists only then.
//  Revision: 1.0  initial release
// ============================================================================
module iir_f2q_sat
    import iir_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic             sign,
    input  fclass_t          cls,
    input  logic [OUT_W-1:0] mag,
    input  logic             pre_ovf,
`ifdef IIR_F2Q_ROUND_EN
    input  logic             guard,
`endif
    output logic [OUT_W-1:0] value,
    output logic             flag_ovf,
    output logic             flag_nan
);

    localparam logic [OUT_W-1:0] POS_SAT = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_SAT = {1'b1, {(OUT_W-1){1'b0}}};
    // 2^(OUT_W-1): the largest magnitude a negative result may carry.
    localparam logic [OUT_W:0]   MAG_LIM = {2'b01, {(OUT_W-1){1'b0}}};

    // One extra bit so a rounding carry out of the top is still visible.
    logic [OUT_W:0] rounded;

    always_comb begin
`ifdef IIR_F2Q_ROUND_EN
        rounded = {1'b0, mag} + {{OUT_W{1'b0}}, guard};
`else
        rounded = {1'b0, mag};
`endif
        value    = '0;
        flag_ovf = 1'b0;
        flag_nan = 1'b0;
        if (cls == NAN) begin
            flag_nan = 1'b1;
        end else if (cls == INF || pre_ovf) begin
            flag_ovf = 1'b1;
            value    = sign ? NEG_SAT : POS_SAT;
        end else if (!sign) begin
            if (rounded >= MAG_LIM) begin
                flag_ovf = 1'b1;
                value    = POS_SAT;
            end else begin
                value = rounded[OUT_W-1:0];
            end
        end else begin
            if (rounded > MAG_LIM) begin
                flag_ovf = 1'b1;
                value    = NEG_SAT;
            end else begin
                // Exactly 2^(OUT_W-1) negates onto NEG_SAT without overflow.
                value = '0 - rounded[OUT_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/iir_f2q.sv
`default_nettype none
// ============================================================================
//  Module  : iir_f2q
//  Purpose : Pipelined IEEE-754 single to saturated signed fixed-point
//            converter with valid/ready on both sides. Output value is
//            x * 2^FRAC_BITS, truncated or rounded, clamped to OUT_W bits.
//  Ports   : clk, reset_l (async, active-low)
//            i_signal[31:0], i_valid, i_ready      -> float input side
//            o_signal[OUT_W-1:0], o_valid, o_ready -> fixed output side
//            o_ovf (saturated / Inf), o_nan (input was NaN)
//  Config  : IIR_F2Q_ROUND_EN -> round to nearest, ties away from zero;
//            undefined -> truncate toward zero.
//  Timing  : sample accepted at edge N is presented after edge N+3.
//  Revision: 1.0  initial release
// ============================================================================
module iir_f2q
    import iir_pkg::*;
#(
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 0
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic [31:0]      i_signal,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [OUT_W-1:0] o_signal,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_ovf,
    output logic             o_nan
);

    // Exponent offset that turns a biased exponent into a left-shift count
    // of the 24-bit significand (negative results mean a right shift).
    localparam int SH_OFS = FLT_BIAS + FLT_MAN_W - FRAC_BITS;

    // Whole pipe moves as one; a stalled output freezes every stage.
    logic adv;
    assign adv     = !o_valid || o_ready;
    assign i_ready = adv;

    // ---------------- capture register -------------------------------------
    logic   cap_v;
    float_t cap_f;

    // ---------------- S1: unpack / classify --------------------------------
    logic        s1_v;
    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [23:0] s1_sig;
    fclass_t     s1_cls;

    // ---------------- S2: align --------------------------------------------
    logic             s2_v;
    logic             s2_sign;
    fclass_t          s2_cls;
    logic [OUT_W-1:0] s2_mag;
    logic             s2_pre_ovf;
`ifdef IIR_F2Q_ROUND_EN
    logic             s2_guard;
    logic             guard_nxt;
    logic [24:0]      rsh;
`endif

    logic [9:0]  shamt;
    logic [9:0]  rshamt;
    logic [63:0] int_part;
    logic        far_left;

    // ---------------- S3: output register ----------------------------------
    logic             out_v;
    logic [OUT_W-1:0] out_sig;
    logic             out_ovf;
    logic             out_nan;

    logic [OUT_W-1:0] sat_value;
    logic             sat_ovf;
    logic             sat_nan;

    // Alignment. int_part is wide enough that a 24-bit significand shifted
    // left by up to 40 never loses a set bit; anything further is flagged
    // directly since OUT_W never exceeds 32.
    always_comb begin
        shamt    = 10'({2'b00, s1_exp}) - 10'(SH_OFS);
        rshamt   = 10'd0 - shamt;
        int_part = '0;
        far_left = 1'b0;
`ifdef IIR_F2Q_ROUND_EN
        guard_nxt = 1'b0;
        rsh       = '0;
`endif
        if (s1_cls == NORM) begin
            if (!shamt[9]) begin
                if (shamt > 10'd40)
                    far_left = 1'b1;
                else
                    int_part = {40'd0, s1_sig} << shamt[5:0];
            end else if (rshamt < 10'd25) begin
`ifdef IIR_F2Q_ROUND_EN
                rsh       = {s1_sig, 1'b0} >> rshamt[4:0];
                int_part  = {40'd0, rsh[24:1]};
                guard_nxt = rsh[0];
`else
                int_part  = {40'd0, s1_sig >> rshamt[4:0]};
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cap_v      <= 1'b0;
            cap_f      <= '0;
            s1_v       <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= '0;
            s1_sig     <= '0;
            s1_cls     <= ZERO;
            s2_v       <= 1'b0;
            s2_sign    <= 1'b0;
            s2_cls     <= ZERO;
            s2_mag     <= '0;
            s2_pre_ovf <= 1'b0;
`ifdef IIR_F2Q_ROUND_EN
            s2_guard   <= 1'b0;
`endif
            out_v      <= 1'b0;
            out_sig    <= '0;
            out_ovf    <= 1'b0;
            out_nan    <= 1'b0;
        end else if (adv) begin
            cap_v      <= i_valid;
            cap_f      <= i_signal;

            s1_v       <= cap_v;
            s1_sign    <= cap_f.sign;
            s1_exp     <= cap_f.exp;
            s1_sig     <= {(cap_f.exp != 8'd0), cap_f.man};
            s1_cls     <= classify(cap_f);

            s2_v       <= s1_v;
            s2_sign    <= s1_sign;
            s2_cls     <= s1_cls;
            s2_mag     <= int_part[OUT_W-1:0];
            s2_pre_ovf <= far_left | (|int_part[63:OUT_W]);
`ifdef IIR_F2Q_ROUND_EN
            s2_guard   <= guard_nxt;
`endif

            out_v <= s2_v;
            // Data only loads on a real sample so a bubble leaves the last
            // result in place instead of churning the output bus.
            if (s2_v) begin
                out_sig <= sat_value;
                out_ovf <= sat_ovf;
                out_nan <= sat_nan;
            end
        end
    end

    iir_f2q_sat #(
        .OUT_W (OUT_W)
    ) u_sat (
        .sign     (s2_sign),
        .cls      (s2_cls),
        .mag      (s2_mag),
        .pre_ovf  (s2_pre_ovf),
`ifdef IIR_F2Q_ROUND_EN
        .guard    (s2_guard),
`endif
        .value    (sat_value),
        .flag_ovf (sat_ovf),
        .flag_nan (sat_nan)
    );

    assign o_valid  = out_v;
    assign o_signal = out_sig;
    assign o_ovf    = out_ovf;
    assign o_nan    = out_nan;

endmodule
`default_nettype wire

// File: tb/tb_iir_f2q.sv
`default_nettype none
// ============================================================================
//  Module  : tb_iir_f2q
//  Purpose : Self-checking bench for iir_f2q. Two instances (FRAC_BITS 0 and
//            8) share stimulus; a table of float vectors with hand-derived
//            results feeds per-instance scoreboard queues, plus hand-written
//            latency, back-pressure and mid-stream reset sequences.
//  Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_iir_f2q;

`ifdef IIR_F2Q_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_l;
    logic [31:0] i_signal;
    logic        i_valid;
    logic        o_ready;

    logic        i_ready0, o_valid0, ovf0, nan0;
    logic [15:0] sig0;
    logic        i_ready8, o_valid8, ovf8, nan8;
    logic [15:0] sig8;

    always #5 clk = ~clk;

    iir_f2q #(.OUT_W(16), .FRAC_BITS(0)) dut0 (
        .clk(clk), .reset_l(reset_l), .i_signal(i_signal), .i_valid(i_valid),
        .i_ready(i_ready0), .o_signal(sig0), .o_valid(o_valid0),
        .o_ready(o_ready), .o_ovf(ovf0), .o_nan(nan0)
    );

    iir_f2q #(.OUT_W(16), .FRAC_BITS(8)) dut8 (
        .clk(clk), .reset_l(reset_l), .i_signal(i_signal), .i_valid(i_valid),
        .i_ready(i_ready8), .o_signal(sig8), .o_valid(o_valid8),
        .o_ready(o_ready), .o_ovf(ovf8), .o_nan(nan8)
    );

    typedef struct {
        logic [31:0] din;
        logic [15:0] e0;
        logic        ovf0;
        logic        nan0;
        logic [15:0] e8;
        logic        ovf8;
        logic        nan8;
    } vec_t;

    typedef struct {
        logic [15:0] val;
        logic        ovf;
        logic        nan;
    } exp_t;

    localparam int NV = 18;
    vec_t vecs[NV];
    vec_t idle_v;
    exp_t q0[$];
    exp_t q8[$];
    int   total = 0;
    int   bad   = 0;
    int   n_out0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock cycle: drive at posedge+1, resolve handshakes at negedge.
    task automatic tick(input logic v, input vec_t vec, input logic rdy, output logic acc);
        exp_t e;
        i_valid  = v;
        i_signal = vec.din;
        o_ready  = rdy;
        @(negedge clk);
        acc = v && i_ready0;
        if (acc) q0.push_back('{vec.e0, vec.ovf0, vec.nan0});
        if (v && i_ready8) q8.push_back('{vec.e8, vec.ovf8, vec.nan8});
        if (o_valid0 && rdy) begin
            n_out0++;
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out0 actual=%h required=none", sig0);
            end else begin
                e = q0.pop_front();
                chk("out0_value", 32'(sig0), 32'(e.val));
                chk("out0_ovf",   32'(ovf0), 32'(e.ovf));
                chk("out0_nan",   32'(nan0), 32'(e.nan));
            end
        end
        if (o_valid8 && rdy) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out8 actual=%h required=none", sig8);
            end else begin
                e = q8.pop_front();
                chk("out8_value", 32'(sig8), 32'(e.val));
                chk("out8_ovf",   32'(ovf8), 32'(e.ovf));
                chk("out8_nan",   32'(nan8), 32'(e.nan));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t vec, input bit rnd_rdy);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            tick(1'b1, vec, rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1, acc);
            n++;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while ((q0.size() != 0 || q8.size() != 0) && n < 60) begin
            tick(1'b0, idle_v, 1'b1, acc);
            n++;
        end
        chk("drain_q0", 32'(q0.size()), 32'd0);
        chk("drain_q8", 32'(q8.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   lat;
        int   n_start;
        int   acc_n;

        //          din           e0                     ovf0 nan0 e8       ovf8 nan8
        vecs[0]  = '{32'h43FA0000, 16'h01F4,             0,   0,   16'h7FFF, 1, 0};
        vecs[1]  = '{32'hC0200000, RND ? 16'hFFFD : 16'hFFFE, 0, 0, 16'hFD80, 0, 0};
        vecs[2]  = '{32'h49742400, 16'h7FFF,             1,   0,   16'h7FFF, 1, 0};
        vecs[3]  = '{32'hC7000000, 16'h8000,             0,   0,   16'h8000, 1, 0};
        vecs[4]  = '{32'h7FC00000, 16'h0000,             0,   1,   16'h0000, 0, 1};
        vecs[5]  = '{32'hFF800000, 16'h8000,             1,   0,   16'h8000, 1, 0};
        vecs[6]  = '{32'h3FC00000, RND ? 16'h0002 : 16'h0001, 0, 0, 16'h0180, 0, 0};
        vecs[7]  = '{32'h00000001, 16'h0000,             0,   0,   16'h0000, 0, 0};
        vecs[8]  = '{32'h80000000, 16'h0000,             0,   0,   16'h0000, 0, 0};
        vecs[9]  = '{32'h47000000, 16'h7FFF,             1,   0,   16'h7FFF, 1, 0};
        vecs[10] = '{32'h3F000000, RND ? 16'h0001 : 16'h0000, 0, 0, 16'h0080, 0, 0};
        vecs[11] = '{32'hBF800000, 16'hFFFF,             0,   0,   16'hFF00, 0, 0};
        vecs[12] = '{32'h46FFFE00, 16'h7FFF,             0,   0,   16'h7FFF, 1, 0};
        vecs[13] = '{32'h46FFFF00, 16'h7FFF,             RND, 0,   16'h7FFF, 1, 0};
        vecs[14] = '{32'hC7000080, 16'h8000,             RND, 0,   16'h8000, 1, 0};
        vecs[15] = '{32'h3E800000, 16'h0000,             0,   0,   16'h0040, 0, 0};
        vecs[16] = '{32'h7F800000, 16'h7FFF,             1,   0,   16'h7FFF, 1, 0};
        vecs[17] = '{32'h7F800001, 16'h0000,             0,   1,   16'h0000, 0, 1};
        idle_v   = '{32'h0, 16'h0, 0, 0, 16'h0, 0, 0};

        reset_l  = 1'b0;
        i_valid  = 1'b0;
        i_signal = '0;
        o_ready  = 1'b0;
        #12;
        chk("rst_o_valid",  32'(o_valid0), 32'd0);
        chk("rst_o_signal", 32'(sig0),     32'd0);
        chk("rst_o_ovf",    32'(ovf0),     32'd0);
        chk("rst_o_nan",    32'(nan0),     32'd0);
        chk("rst_i_ready",  32'(i_ready0), 32'd1);
        chk("rst_o_valid8", 32'(o_valid8), 32'd0);
        @(posedge clk);
        #1;
        reset_l = 1'b1;

        // Latency of a single 500.0 sample with o_ready held high.
        i_valid  = 1'b1;
        i_signal = 32'h43FA0000;
        o_ready  = 1'b1;
        @(negedge clk);
        chk("lat_accept", 32'(i_ready0), 32'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid0 && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency",      32'(lat),      32'd3);
        chk("lat_value",    32'(sig0),     32'h01F4);
        chk("lat_flags",    32'({ovf0, nan0}), 32'd0);
        chk("lat_valid8",   32'(o_valid8), 32'd1);
        chk("lat_value8",   32'(sig8),     32'h7FFF);
        chk("lat_ovf8",     32'(ovf8),     32'd1);
        @(posedge clk);
        #1;
        chk("lat_drained",  32'(o_valid0), 32'd0);

        // Table, back-to-back with the sink always ready.
        for (int i = 0; i < NV; i++) apply(vecs[i], 1'b0);
        drain();

        // Table again under random sink back-pressure.
        for (int i = 0; i < NV; i++) apply(vecs[NV-1-i], 1'b1);
        drain();

        // Ten 500.0 samples with a five-cycle sink stall mid-burst.
        n_start = n_out0;
        acc_n   = 0;
        for (int c = 0; c < 80 && (acc_n < 10 || q0.size() != 0 || q8.size() != 0); c++) begin
            tick(acc_n < 10, vecs[0], !(c >= 5 && c < 10), acc);
            if (acc) acc_n++;
            if (c >= 5 && c < 10) begin
                chk("stall_o_valid", 32'(o_valid0), 32'd1);
                chk("stall_i_ready", 32'(i_ready0), 32'd0);
                chk("stall_hold",    32'(sig0),     32'h01F4);
            end
        end
        chk("burst_count", 32'(n_out0 - n_start), 32'd10);
        drain();

        // Reset with the pipe full and the sink stalled.
        for (int i = 0; i < 4; i++) tick(1'b1, vecs[0], 1'b0, acc);
        #2;
        reset_l = 1'b0;
        #1;
        chk("mid_rst_o_valid",  32'(o_valid0), 32'd0);
        chk("mid_rst_o_valid8", 32'(o_valid8), 32'd0);
        chk("mid_rst_o_signal", 32'(sig0),     32'd0);
        q0.delete();
        q8.delete();
        @(posedge clk);
        #1;
        reset_l = 1'b1;
        tick(1'b1, vecs[1], 1'b1, acc);
        chk("post_rst_accept", 32'(acc), 32'd1);
        for (int i = 0; i < 6; i++) tick(1'b0, idle_v, 1'b1, acc);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
